i2c_burst_wrapper: RTL

I2C_BURST_WRAPPER -- requirements
Module: i2c_burst_wrapper

---
 rtl/i2c_burst_wrapper.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/i2c_burst_wrapper.sv
// Burst-capable register file fronted by a shift register: writes commit after WRITE_LAT
// cycles, and reads stream blen+1 consecutive wrapping words after READ_LAT cycles.
module i2c_burst_wrapper #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 4,
  parameter int BLEN_W    = 3,
  parameter int WRITE_LAT = 2,
  parameter int READ_LAT  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATAWIDTH-1:0]         D,
  input  logic [$clog2(DATAWIDTH)-1:0] S,
  input  logic                         MSBIn,
  input  logic                         LSBIn,
  input  logic [ADDRWIDTH-1:0]         addr,
  input  logic [BLEN_W-1:0]            blen,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic                         ready,
  output logic [DATAWIDTH-1:0]         dataout,
  output logic                         DataValid,
  output logic                         last,
  output logic                         cmd_drop
);

  localparam int S_W   = $clog2(DATAWIDTH);
  localparam int DEPTH = 2 ** ADDRWIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_WAIT  = 2'd2,
    RD_BURST = 2'd3
  } state_t;

  state_t                 state_r;
  logic [DATAWIDTH-1:0]   sr_r;
  logic [DATAWIDTH-1:0]   mem_r [DEPTH];
  logic [ADDRWIDTH-1:0]   addr_r;
  logic [BLEN_W-1:0]      blen_r;
  logic [BLEN_W:0]        bidx_r;
  logic [7:0]             lat_cnt_r;
  logic [DATAWIDTH-1:0]   sr_nxt_s;
  logic [ADDRWIDTH-1:0]   rd_addr_s;
  logic                   beat_last_s;

  // Shift-register update selected by mode; unused modes hold the current value.
  function automatic logic [DATAWIDTH-1:0] sr_next(
    input logic [S_W-1:0]       mode,
    input logic [DATAWIDTH-1:0] cur,
    input logic [DATAWIDTH-1:0] din,
    input logic                 msb_in,
    input logic                 lsb_in
  );
    case (mode)
      S_W'(1):  sr_next = din;
      S_W'(2):  sr_next = {msb_in, cur[DATAWIDTH-1:1]};
      S_W'(3):  sr_next = {cur[DATAWIDTH-2:0], lsb_in};
      default:  sr_next = cur;
    endcase
  endfunction

  // Next shift-register value and current beat address (wraps modulo depth).
  always_comb begin
    sr_nxt_s    = sr_next(S, sr_r, D, MSBIn, LSBIn);
    rd_addr_s   = addr_r + ADDRWIDTH'(bidx_r);
    beat_last_s = (bidx_r == {1'b0, blen_r});
  end

  // Command FSM, memory and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      sr_r      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      addr_r    <= '0;
      blen_r    <= '0;
      bidx_r    <= '0;
      lat_cnt_r <= 8'd0;
      dataout   <= '0;
      DataValid <= 1'b0;
      last      <= 1'b0;
      cmd_drop  <= 1'b0;
      ready     <= 1'b0;
    end else begin
      DataValid <= 1'b0;
      last      <= 1'b0;
      cmd_drop  <= ~ready & (wr_en | rd_en);
      case (state_r)
        IDLE: begin
          if (ready && wr_en) begin
            sr_r      <= sr_nxt_s;
            addr_r    <= addr;
            lat_cnt_r <= 8'(WRITE_LAT - 1);
            state_r   <= WRITE;
            ready     <= 1'b0;
          end else if (ready && rd_en) begin
            addr_r    <= addr;
            blen_r    <= blen;
            bidx_r    <= '0;
            lat_cnt_r <= 8'(READ_LAT - 1);
            state_r   <= RD_WAIT;
            ready     <= 1'b0;
          end else begin
            ready     <= 1'b1;
          end
        end
        WRITE: begin
          if (lat_cnt_r == 8'd0) begin
            mem_r[addr_r] <= sr_r;
            state_r       <= IDLE;
            ready         <= 1'b1;
          end else begin
            lat_cnt_r     <= lat_cnt_r - 8'd1;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_r == 8'd0) begin
            DataValid <= 1'b1;
            dataout   <= mem_r[rd_addr_s];
            last      <= beat_last_s;
            bidx_r    <= bidx_r + 1'b1;
            state_r   <= RD_BURST;
          end else begin
            lat_cnt_r <= lat_cnt_r - 8'd1;
          end
        end
        RD_BURST: begin
          // bidx_r runs one past blen once the final beat has been presented
          if (bidx_r > {1'b0, blen_r}) begin
            state_r   <= IDLE;
            ready     <= 1'b1;
          end else begin
            DataValid <= 1'b1;
            dataout   <= mem_r[rd_addr_s];
            last      <= beat_last_s;
            bidx_r    <= bidx_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule
